// File: rtl/pc_gen.sv
// Next-PC generator for the multi-cycle core.
// Owns the architectural PC and issues one fetch per instruction.
module pc_gen #(
   parameter int unsigned ISA_WIDTH = 32,
   parameter logic [ISA_WIDTH-1:0] RESET_VECTOR = ISA_WIDTH'(32'h8000_0000),
   parameter int unsigned IALIGN = 32,
   parameter int unsigned CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 fetch_valid,
   input  logic                 fetch_ready,
   output logic [ISA_WIDTH-1:0] fetch_pc,
   input  logic                 commit_valid,
   input  logic [2:0]           commit_kind,
   input  logic                 commit_taken,
   input  logic                 commit_rvc,
   input  logic [ISA_WIDTH-1:0] commit_base,
   input  logic [ISA_WIDTH-1:0] commit_imm,
   input  logic                 trap_valid,
   input  logic [ISA_WIDTH-1:0] mtvec,
   output logic                 exc_valid,
   output logic [ISA_WIDTH-1:0] exc_tval,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] instret
);

   if (IALIGN != 16 && IALIGN != 32) begin : g_ialign_chk
      $error("pc_gen: IALIGN must be 16 or 32");
   end

   localparam bit ALIGN32 = (IALIGN == 32);
   localparam bit ALIGN16 = (IALIGN == 16);

   localparam logic [2:0] K_BRANCH = 3'd1;
   localparam logic [2:0] K_JAL    = 3'd2;
   localparam logic [2:0] K_JALR   = 3'd3;
   localparam logic [2:0] K_HALT   = 3'd4;

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_HALT
   } state_t;

   state_t state, state_n;

   logic [ISA_WIDTH-1:0] pc, pc_n;
   logic [ISA_WIDTH-1:0] exc_tval_n;
   logic [CNT_WIDTH-1:0] instret_n;
   logic                 exc_valid_n;
   logic                 halted_n;

   logic [ISA_WIDTH-1:0] ilen;
   logic [ISA_WIDTH-1:0] seq_pc;
   logic [ISA_WIDTH-1:0] target;
   logic                 redirect;
   logic                 misaligned;

   assign fetch_valid = (state == S_REQ);
   assign fetch_pc    = pc;

   always_comb begin
      ilen     = (ALIGN16 && commit_rvc) ? ISA_WIDTH'(2) : ISA_WIDTH'(4);
      seq_pc   = pc + ilen;
      target   = seq_pc;
      redirect = 1'b0;
      case (commit_kind)
         K_BRANCH: begin
            if (commit_taken) begin
               target   = pc + commit_imm;
               redirect = 1'b1;
            end
         end
         K_JAL: begin
            target   = pc + commit_imm;
            redirect = 1'b1;
         end
         K_JALR: begin
            target   = (commit_base + commit_imm) & ~ISA_WIDTH'(1);
            redirect = 1'b1;
         end
         default: ;
      endcase
      // only redirects can land off-grid; sequential steps never do
      misaligned = redirect && (target[0] || (ALIGN32 && target[1]));
   end

   always_comb begin
      state_n     = state;
      pc_n        = pc;
      exc_valid_n = 1'b0;
      exc_tval_n  = exc_tval;
      halted_n    = halted;
      instret_n   = instret;
      case (state)
         S_BOOT: state_n = S_REQ;
         S_REQ: begin
            if (fetch_ready) state_n = S_WAIT;
         end
         S_WAIT: begin
            if (trap_valid) begin
               pc_n    = mtvec;
               state_n = S_REQ;
            end else if (commit_valid) begin
               if (commit_kind == K_HALT) begin
                  instret_n = instret + CNT_WIDTH'(1);
                  halted_n  = 1'b1;
                  state_n   = S_HALT;
               end else if (misaligned) begin
                  exc_valid_n = 1'b1;
                  exc_tval_n  = target;
                  pc_n        = mtvec;
                  state_n     = S_REQ;
               end else begin
                  pc_n      = target;
                  instret_n = instret + CNT_WIDTH'(1);
                  state_n   = S_REQ;
               end
            end
         end
         S_HALT: ;
         default: state_n = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_BOOT;
         pc        <= RESET_VECTOR;
         exc_valid <= 1'b0;
         exc_tval  <= '0;
         halted    <= 1'b0;
         instret   <= '0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         exc_valid <= exc_valid_n;
         exc_tval  <= exc_tval_n;
         halted    <= halted_n;
         instret   <= instret_n;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: one IALIGN=32 and one IALIGN=16 instance
// share stimulus; a reference model predicts fetches and exceptions.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h8000_0000;

   typedef struct {
      logic [31:0] pc;
      logic [63:0] ret;
   } fexp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_ready = 1'b0;
   logic        commit_valid = 1'b0;
   logic [2:0]  commit_kind = '0;
   logic        commit_taken = 1'b0;
   logic        commit_rvc = 1'b0;
   logic [31:0] commit_base = '0;
   logic [31:0] commit_imm = '0;
   logic        trap_valid = 1'b0;
   logic [31:0] mtvec = 32'h8000_0100;

   logic        fv0, fv1, ev0, ev1, h0, h1;
   logic [31:0] fpc0, fpc1, et0, et1;
   logic [63:0] ir0, ir1;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] m_pc[2];
   logic [63:0] m_ret[2];
   fexp_t       fq0[$];
   fexp_t       fq1[$];
   logic [31:0] eq0[$];
   logic [31:0] eq1[$];

   always #5 clk = ~clk;

   pc_gen #(.IALIGN(32)) dut0 (
      .clk(clk), .rst(rst),
      .fetch_valid(fv0), .fetch_ready(fetch_ready), .fetch_pc(fpc0),
      .commit_valid(commit_valid), .commit_kind(commit_kind),
      .commit_taken(commit_taken), .commit_rvc(commit_rvc),
      .commit_base(commit_base), .commit_imm(commit_imm),
      .trap_valid(trap_valid), .mtvec(mtvec),
      .exc_valid(ev0), .exc_tval(et0), .halted(h0), .instret(ir0)
   );

   pc_gen #(.IALIGN(16)) dut1 (
      .clk(clk), .rst(rst),
      .fetch_valid(fv1), .fetch_ready(fetch_ready), .fetch_pc(fpc1),
      .commit_valid(commit_valid), .commit_kind(commit_kind),
      .commit_taken(commit_taken), .commit_rvc(commit_rvc),
      .commit_base(commit_base), .commit_imm(commit_imm),
      .trap_valid(trap_valid), .mtvec(mtvec),
      .exc_valid(ev1), .exc_tval(et1), .halted(h1), .instret(ir1)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_evt(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: event seen/missing, expected none", name);
   endtask

   function automatic void push_fetch(input int k);
      fexp_t f;
      f.pc = m_pc[k];
      f.ret = m_ret[k];
      if (k == 0) fq0.push_back(f);
      else fq1.push_back(f);
   endfunction

   // Reference model: architectural effect of one WAIT-state event.
   function automatic void model(input int k, input logic [2:0] kind,
                                 input logic taken, input logic rvc,
                                 input logic [31:0] base,
                                 input logic [31:0] imm, input logic trap,
                                 input logic [31:0] mt);
      int unsigned bytes;
      logic [31:0] len;
      logic [31:0] tgt;
      bytes = (k == 0) ? 4 : 2;
      if (trap) begin
         m_pc[k] = mt;
         push_fetch(k);
         return;
      end
      if (kind == 3'd4) begin
         m_ret[k] = m_ret[k] + 1;
         return;
      end
      len = (bytes == 2 && rvc) ? 32'd2 : 32'd4;
      case (kind)
         3'd1: tgt = taken ? m_pc[k] + imm : m_pc[k] + len;
         3'd2: tgt = m_pc[k] + imm;
         3'd3: tgt = (base + imm) & 32'hFFFF_FFFE;
         default: tgt = m_pc[k] + len;
      endcase
      if (tgt % bytes != 0) begin
         if (k == 0) eq0.push_back(tgt);
         else eq1.push_back(tgt);
         m_pc[k] = mt;
      end else begin
         m_pc[k] = tgt;
         m_ret[k] = m_ret[k] + 1;
      end
      push_fetch(k);
   endfunction

   task automatic mon(input int k, input logic fv, input logic fr,
                      input logic [31:0] fpc, input logic [63:0] ir,
                      input logic ev, input logic [31:0] et);
      fexp_t f;
      logic [31:0] t;
      bit got;
      if (fv && fr) begin
         got = 0;
         if (k == 0 && fq0.size() != 0) begin f = fq0.pop_front(); got = 1; end
         if (k == 1 && fq1.size() != 0) begin f = fq1.pop_front(); got = 1; end
         if (!got) fail_evt($sformatf("unexpected_fetch[%0d]", k));
         else begin
            chk($sformatf("fetch_pc[%0d]", k), 64'(fpc), 64'(f.pc));
            chk($sformatf("instret[%0d]", k), ir, f.ret);
         end
      end
      if (ev) begin
         got = 0;
         if (k == 0 && eq0.size() != 0) begin t = eq0.pop_front(); got = 1; end
         if (k == 1 && eq1.size() != 0) begin t = eq1.pop_front(); got = 1; end
         if (!got) fail_evt($sformatf("unexpected_exc[%0d]", k));
         else chk($sformatf("exc_tval[%0d]", k), 64'(et), 64'(t));
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mon(0, fv0, fetch_ready, fpc0, ir0, ev0, et0);
         mon(1, fv1, fetch_ready, fpc1, ir1, ev1, et1);
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_fv0"}, 64'(fv0), 64'd0);
      chk({tag, "_fv1"}, 64'(fv1), 64'd0);
      chk({tag, "_pc0"}, 64'(fpc0), 64'(RV));
      chk({tag, "_pc1"}, 64'(fpc1), 64'(RV));
      chk({tag, "_ev0"}, 64'(ev0), 64'd0);
      chk({tag, "_ev1"}, 64'(ev1), 64'd0);
      chk({tag, "_et0"}, 64'(et0), 64'd0);
      chk({tag, "_et1"}, 64'(et1), 64'd0);
      chk({tag, "_h0"}, 64'(h0), 64'd0);
      chk({tag, "_h1"}, 64'(h1), 64'd0);
      chk({tag, "_ir0"}, ir0, 64'd0);
      chk({tag, "_ir1"}, ir1, 64'd0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      fetch_ready = 1'b0;
      commit_valid = 1'b0;
      trap_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         m_pc[k] = RV;
         m_ret[k] = '0;
      end
      fq0.delete();
      fq1.delete();
      eq0.delete();
      eq1.delete();
      push_fetch(0);
      push_fetch(1);
      #1;
      chk_reset("reset");
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("boot_fv0", 64'(fv0), 64'd0);
      chk("boot_fv1", 64'(fv1), 64'd0);
   endtask

   task automatic fetch_phase(input int stall);
      int n;
      n = 0;
      fetch_ready = 1'b0;
      do begin
         @(negedge clk);
         n++;
      end while (!(fv0 && fv1) && n < 20);
      if (!(fv0 && fv1)) begin
         fail_evt("fetch_valid_timeout");
         return;
      end
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         commit_valid = 1'($urandom);
         trap_valid = 1'($urandom);
         @(negedge clk);
         chk("stall_fv0", 64'(fv0), 64'd1);
         chk("stall_fv1", 64'(fv1), 64'd1);
         chk("stall_pc0", 64'(fpc0), 64'(m_pc[0]));
         chk("stall_pc1", 64'(fpc1), 64'(m_pc[1]));
      end
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      trap_valid = 1'b0;
      fetch_ready = 1'b1;
      @(posedge clk);
      #1;
      fetch_ready = 1'b0;
      chk("wait_fv", 64'({fv0, fv1}), 64'd0);
   endtask

   task automatic commit_phase(input logic [2:0] kind, input logic taken,
                               input logic rvc, input logic [31:0] base,
                               input logic [31:0] imm, input logic trap,
                               input logic [31:0] mt, input int w);
      repeat (w) begin
         @(posedge clk);
         #1;
      end
      commit_valid = 1'b1;
      commit_kind = kind;
      commit_taken = taken;
      commit_rvc = rvc;
      commit_base = base;
      commit_imm = imm;
      trap_valid = trap;
      mtvec = mt;
      model(0, kind, taken, rvc, base, imm, trap, mt);
      model(1, kind, taken, rvc, base, imm, trap, mt);
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      trap_valid = 1'b0;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [2:0]  kd;
      logic [31:0] im;
      logic [31:0] mt;
      mt = 32'h8000_0100;
      do_reset();

      fetch_phase(0);
      commit_phase(3'd0, 0, 0, 0, 0, 0, mt, 0);
      fetch_phase(5);
      commit_phase(3'd2, 0, 0, 0, 32'h0000_000C, 0, mt, 1);
      fetch_phase(0);
      commit_phase(3'd1, 1, 0, 0, 32'hFFFF_FFF0, 0, mt, 0);
      fetch_phase(0);
      commit_phase(3'd2, 0, 0, 0, 32'h0000_0010, 0, mt, 0);
      fetch_phase(0);
      commit_phase(3'd1, 0, 0, 0, 32'hFFFF_FFF0, 0, mt, 0);
      fetch_phase(0);
      commit_phase(3'd3, 0, 0, 32'h8000_1003, 32'h0, 0, mt, 0);
      fetch_phase(0);
      commit_phase(3'd2, 0, 0, 0, 32'h0000_0040, 1, mt, 2);
      fetch_phase(1);
      commit_phase(3'd0, 0, 1, 0, 0, 0, mt, 0);
      fetch_phase(0);
      commit_phase(3'd7, 1, 0, 0, 32'h0000_0100, 0, mt, 0);

      for (int i = 0; i < 150; i++) begin
         kd = 3'($urandom_range(0, 7));
         if (kd == 3'd4) kd = 3'd0;
         im = 32'($urandom_range(0, 63)) - 32'd32;
         if ($urandom_range(0, 7) != 0) im = im << 1;
         mt = $urandom & 32'hFFFF_FFFC;
         fetch_phase(int'($urandom_range(0, 3)));
         commit_phase(kd, 1'($urandom), 1'($urandom), $urandom, im,
                      ($urandom_range(0, 9) == 0), mt,
                      int'($urandom_range(0, 2)));
      end

      fetch_phase(0);
      chk("fetch_q_drained", 64'(fq0.size() + fq1.size()), 64'd0);
      chk("exc_q_drained", 64'(eq0.size() + eq1.size()), 64'd0);

      commit_phase(3'd4, 0, 0, 0, 0, 0, mt, 0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("halt_fv", 64'({fv0, fv1}), 64'd0);
         chk("halted", 64'({h0, h1}), 64'd3);
         chk("halt_ir0", ir0, m_ret[0]);
         chk("halt_ir1", ir1, m_ret[1]);
         @(posedge clk);
         #1;
         fetch_ready = 1'b1;
         commit_valid = 1'($urandom);
         trap_valid = 1'($urandom);
         commit_kind = 3'($urandom);
      end
      commit_valid = 1'b0;
      trap_valid = 1'b0;

      do_reset();
      fetch_phase(0);
      commit_phase(3'd3, 0, 0, 32'h8000_2006, 32'h0, 0, 32'h8000_0200, 0);
      fetch_phase(0);
      commit_phase(3'd0, 0, 0, 0, 0, 0, mt, 0);
      fetch_phase(0);
      chk("pre_reset_ir0", ir0, 64'd1);
      rst = 1'b0;
      #1;
      chk_reset("midwait");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Sequential next-PC generator for the multi-cycle core; sits between EXU (commit/redirect) and IFU (fetch request).
- Owns the architectural PC register and issues one fetch request per instruction over a valid/ready handshake.
- Computes the next PC from the committed instruction kind.
- Adds features the single-cycle next-PC logic lacks: parametrised width, reset vector and alignment; misaligned-target exception; trap redirect; halt; retired-instruction counter.

Parameters:
- ISA_WIDTH, 32: PC/data width in bits.
- RESET_VECTOR, 32'h8000_0000: PC value loaded on reset.
- IALIGN, 32: instruction alignment in bits; only 16 or 32 are legal.
- CNT_WIDTH, 64: width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- fetch_valid  out  1  fetch request valid.
- fetch_ready  in  1  IFU accepts the request.
- fetch_pc  out  ISA_WIDTH  address to fetch; equals the current PC.
- commit_valid  in  1  EXU finished the in-flight instruction.
- commit_kind  in  3  0 SEQ, 1 BRANCH, 2 JAL, 3 JALR, 4 HALT; 5-7 are treated as SEQ.
- commit_taken  in  1  branch outcome; used only for BRANCH.
- commit_rvc  in  1  instruction is 2 bytes long; ignored when IALIGN=32.
- commit_base  in  ISA_WIDTH  rs1 value; used only for JALR.
- commit_imm  in  ISA_WIDTH  sign-extended immediate.
- trap_valid  in  1  synchronous trap (ecall/illegal) for the in-flight instruction.
- mtvec  in  ISA_WIDTH  trap target.
- exc_valid  out  1  one-cycle pulse: instruction-address-misaligned exception.
- exc_tval  out  ISA_WIDTH  the faulting target address, valid with exc_valid.
- halted  out  1  core halted.
- instret  out  CNT_WIDTH  retired-instruction count.

Behaviour:
- States: BOOT, REQ, WAIT, HALT.
- Reset (rst=0, asynchronous):
  - pc = RESET_VECTOR, state = BOOT.
  - fetch_valid = 0, exc_valid = 0, exc_tval = 0, halted = 0, instret = 0.
- BOOT: lasts one cycle after reset release, then moves to REQ. fetch_valid = 0 in this cycle.
- REQ:
  - fetch_valid = 1 and fetch_pc = pc.
  - Both stay stable while fetch_ready = 0.
  - On a cycle with fetch_valid & fetch_ready, move to WAIT.
  - commit_valid and trap_valid are ignored in REQ.
- WAIT:
  - fetch_valid = 0; the state holds until commit_valid or trap_valid.
  - Priority: trap_valid > HALT > other kinds.
  - trap_valid: pc <= mtvec, go to REQ, instret unchanged. A commit in the same cycle is discarded.
  - HALT (commit_valid, kind 4): pc unchanged, instret += 1, halted <= 1, go to HALT.
  - ilen = 2 if (IALIGN==16 && commit_rvc), else 4.
  - Next-PC targets:
    - SEQ: pc + ilen.
    - BRANCH: taken ? pc + imm : pc + ilen.
    - JAL: pc + imm.
    - JALR: (base + imm) with bit 0 forced to 0.
  - All adds are modulo 2^ISA_WIDTH; there is no overflow flag.
  - Misalignment test on the computed target: bit 0 set (impossible after the JALR mask), or bit 1 set when IALIGN=32.
  - Misaligned target:
    - exc_valid = 1 for exactly the next cycle, with exc_tval = target.
    - pc <= mtvec, go to REQ, instret unchanged.
    - Applies only to redirecting kinds; a SEQ or not-taken target is always aligned.
  - Otherwise: pc <= target, instret += 1, go to REQ.
- HALT: absorbing state; fetch_valid = 0, all inputs ignored; left only by reset.
- instret wraps to 0 after all-ones, with no saturation.
- Output registers: exc_valid, exc_tval and halted are registered.
- Combinational outputs: fetch_valid and fetch_pc are decoded from state and pc; there is no combinational path from any input.
- An illegal IALIGN value triggers an elaboration-time error.

Test Plan:
- Reset, then release; fetch_ready = 1: cycle 0 fetch_valid = 0, cycle 1 fetch_pc = 0x8000_0000. Commit SEQ -> next fetch_pc = 0x8000_0004, instret = 1.
- fetch_ready held low for 5 cycles -> fetch_valid and fetch_pc stay stable; pc does not change; then ready=1 -> state moves to WAIT.
- Branches at pc 0x8000_0010 with imm = -16:
  - taken -> 0x8000_0000.
  - not taken -> 0x8000_0014.
- JALR with base 0x8000_1003, imm 0:
  - IALIGN=16 -> 0x8000_1002, no exception.
  - IALIGN=32 -> exc_valid pulse with exc_tval 0x8000_1002, then fetch_pc = mtvec, instret unchanged.
- trap_valid and commit JAL in the same cycle, mtvec = 0x8000_0100 -> fetch_pc = 0x8000_0100, instret unchanged.
- Commit HALT -> halted = 1 and fetch_valid stays 0 for 20 cycles. Assert rst mid-WAIT -> outputs immediately return to their reset values.
